// File: rtl/mdu_sequencer_if.sv
// Pipeline-side bundle for the iterative multiply/divide sequencer:
// request, shared-ALU borrow path and architectural HI/LO/dz results.
interface mdu_sequencer_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] alu_res;
    logic        alu_grant;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic        busy;
    logic        done;
    logic        dz;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_val, rt_val, alu_res,
        input  alu_grant, alu_a, alu_b, alu_ctrl, busy, done, dz, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val, alu_res,
        output alu_grant, alu_a, alu_b, alu_ctrl, busy, done, dz, hi, lo
    );
endinterface

// File: rtl/mdu_sequencer.sv
// Unsigned MULTU/DIVU sequencer: one shared-ALU add/subtract per cycle for
// 32 steps, then a single FIN cycle commits HI/LO. Also services MTHI/MTLO.
module mdu_sequencer #(
    parameter logic [3:0]  CTRL_ADD = 4'b0010,
    parameter logic [3:0]  CTRL_SUB = 4'b0110,
    parameter logic [31:0] HILO_RST = 32'h0
) (
    input logic          clk,
    input logic          rst_n,
    mdu_sequencer_if.slave bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    logic [1:0]  state;
    logic [4:0]  cnt;
    logic [31:0] acc;      // product high half (MUL) or partial remainder (DIV)
    logic [31:0] q;        // multiplier / quotient shift register
    logic [31:0] m;        // multiplicand or divisor
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        is_div;
    logic        dz_pending;
    logic        dz_r;

    logic [31:0] t;
    logic        ge;
    logic [31:0] sum;
    logic        carry;

    always_comb begin
        t     = {acc[30:0], q[31]};
        // acc[31] set means the shifted remainder already exceeds 2^32 > D
        ge    = acc[31] | (t >= m);
        sum   = q[0] ? bus.alu_res : acc;
        carry = q[0] & (bus.alu_res < acc);

        bus.alu_grant = (state == S_MUL) || (state == S_DIV);
        bus.alu_a     = '0;
        bus.alu_b     = '0;
        bus.alu_ctrl  = '0;
        if (state == S_MUL) begin
            bus.alu_a    = acc;
            bus.alu_b    = m;
            bus.alu_ctrl = CTRL_ADD;
        end else if (state == S_DIV) begin
            bus.alu_a    = t;
            bus.alu_b    = m;
            bus.alu_ctrl = CTRL_SUB;
        end

        bus.busy = (state != S_IDLE);
        bus.done = (state == S_FIN);
        bus.dz   = dz_r;
        bus.hi   = hi_r;
        bus.lo   = lo_r;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            acc        <= '0;
            q          <= '0;
            m          <= '0;
            hi_r       <= HILO_RST;
            lo_r       <= HILO_RST;
            is_div     <= 1'b0;
            dz_pending <= 1'b0;
            dz_r       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            2'b00: begin
                                m          <= bus.rs_val;
                                acc        <= '0;
                                q          <= bus.rt_val;
                                cnt        <= '0;
                                is_div     <= 1'b0;
                                dz_pending <= 1'b0;
                                state      <= S_MUL;
                            end
                            2'b01: begin
                                m          <= bus.rt_val;
                                acc        <= '0;
                                q          <= bus.rs_val;
                                cnt        <= '0;
                                is_div     <= 1'b1;
                                dz_pending <= (bus.rt_val == '0);
                                state      <= (bus.rt_val == '0) ? S_FIN : S_DIV;
                            end
                            2'b10:   hi_r <= bus.rs_val;
                            default: lo_r <= bus.rs_val;
                        endcase
                    end
                end
                S_MUL: begin
                    acc <= {carry, sum[31:1]};
                    q   <= {sum[0], q[31:1]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= S_FIN;
                end
                S_DIV: begin
                    if (ge) begin
                        acc <= bus.alu_res;
                        q   <= {q[30:0], 1'b1};
                    end else begin
                        acc <= t;
                        q   <= {q[30:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) state <= S_FIN;
                end
                default: begin
                    // divide-by-zero keeps the untouched dividend in q
                    if (dz_pending) begin
                        hi_r <= q;
                        lo_r <= '1;
                    end else begin
                        hi_r <= acc;
                        lo_r <= q;
                    end
                    if (is_div) dz_r <= dz_pending;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed and randomized bench for mdu_sequencer against an arithmetic
// reference model of HI/LO/dz and the cycle-level busy/done/grant timing.
module tb_mdu_sequencer;

    localparam logic [3:0] ADD = 4'b0010;
    localparam logic [3:0] SUB = 4'b0110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_sequencer_if bus();

    mdu_sequencer #(
        .CTRL_ADD(ADD),
        .CTRL_SUB(SUB),
        .HILO_RST(32'h0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus.slave)
    );

    // shared ALU stand-in
    assign bus.alu_res = (bus.alu_ctrl == SUB) ? bus.alu_a - bus.alu_b
                                               : bus.alu_a + bus.alu_b;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_hi = 32'h0;
    logic [31:0] exp_lo = 32'h0;
    logic        exp_dz = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        case (op)
            2'b00: begin
                p = 64'(a) * 64'(b);
                exp_hi = p[63:32];
                exp_lo = p[31:0];
            end
            2'b01: begin
                if (b == 32'h0) begin
                    exp_hi = a;
                    exp_lo = 32'hFFFF_FFFF;
                    exp_dz = 1'b1;
                end else begin
                    exp_hi = a % b;
                    exp_lo = a / b;
                    exp_dz = 1'b0;
                end
            end
            2'b10:   exp_hi = a;
            default: exp_lo = a;
        endcase
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit inject);
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        logic        old_dz;
        int          len;
        old_hi = exp_hi;
        old_lo = exp_lo;
        old_dz = exp_dz;
        if (op == 2'b00)                     len = 33;
        else if (op == 2'b01 && b != 32'h0)  len = 33;
        else if (op == 2'b01)                len = 1;
        else                                 len = 0;

        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.rs_val = a;
        bus.rt_val = b;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.op     = 2'($urandom);
        bus.rs_val = $urandom;
        bus.rt_val = $urandom;
        model(op, a, b);

        for (int k = 1; k <= len; k++) begin
            chk("busy_op", 32'(bus.busy), 32'd1);
            chk("done_op", 32'(bus.done), 32'(k == len));
            chk("grant_op", 32'(bus.alu_grant), 32'(k < len));
            chk("ctrl_op", 32'(bus.alu_ctrl),
                (k < len) ? ((op == 2'b00) ? 32'(ADD) : 32'(SUB)) : 32'd0);
            chk("hi_hold", bus.hi, old_hi);
            chk("lo_hold", bus.lo, old_lo);
            chk("dz_hold", 32'(bus.dz), 32'(old_dz));
            if (inject && k == 10) begin
                bus.start  = 1'b1;
                bus.op     = 2'b11;
                bus.rs_val = 32'h1234_5678;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
        end

        chk("busy_after", 32'(bus.busy), 32'd0);
        chk("done_after", 32'(bus.done), 32'd0);
        chk("grant_after", 32'(bus.alu_grant), 32'd0);
        chk("alu_a_idle", bus.alu_a, 32'd0);
        chk("hi_result", bus.hi, exp_hi);
        chk("lo_result", bus.lo, exp_lo);
        chk("dz_result", 32'(bus.dz), 32'(exp_dz));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.start  = 1'b0;
        bus.op     = 2'b00;
        bus.rs_val = 32'h0;
        bus.rt_val = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_dz", 32'(bus.dz), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_grant", 32'(bus.alu_grant), 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        chk("rst_alu_ctrl", 32'(bus.alu_ctrl), 32'd0);
        rst_n = 1'b1;

        run_op(2'b00, 32'd7, 32'd6, 1'b0);
        chk("mul_7x6_lo", bus.lo, 32'd42);
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("mul_max_hi", bus.hi, 32'hFFFF_FFFE);
        chk("mul_max_lo", bus.lo, 32'h0000_0001);
        run_op(2'b01, 32'd100, 32'd7, 1'b0);
        chk("div_100_7_lo", bus.lo, 32'd14);
        chk("div_100_7_hi", bus.hi, 32'd2);
        run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        chk("div_big_lo", bus.lo, 32'd1);
        chk("div_big_hi", bus.hi, 32'h7FFF_FFFF);
        run_op(2'b01, 32'd5, 32'd0, 1'b0);
        chk("dz_hi", bus.hi, 32'd5);
        chk("dz_lo", bus.lo, 32'hFFFF_FFFF);
        chk("dz_flag", 32'(bus.dz), 32'd1);
        run_op(2'b01, 32'd9, 32'd3, 1'b0);
        chk("dz_clear", 32'(bus.dz), 32'd0);
        chk("div_9_3_lo", bus.lo, 32'd3);

        run_op(2'b10, 32'hA5A5_A5A5, 32'h0, 1'b0);
        chk("mthi", bus.hi, 32'hA5A5_A5A5);
        run_op(2'b00, 32'd3, 32'd3, 1'b1);
        chk("mul_3x3_hi", bus.hi, 32'd0);
        chk("mul_3x3_lo", bus.lo, 32'd9);
        run_op(2'b11, 32'hDEAD_BEEF, 32'h0, 1'b0);
        chk("mtlo", bus.lo, 32'hDEAD_BEEF);

        // reset in the middle of a multiply
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = 2'b00;
        bus.rs_val = 32'd7;
        bus.rt_val = 32'd6;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        chk("busy_pre_rst", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_hi = 32'h0;
        exp_lo = 32'h0;
        exp_dz = 1'b0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_hi", bus.hi, 32'h0);
        chk("midrst_lo", bus.lo, 32'h0);
        chk("midrst_grant", 32'(bus.alu_grant), 32'd0);
        for (int i = 0; i < 25; i++) begin
            chk("midrst_no_done", 32'(bus.done), 32'd0);
            @(posedge clk); #1;
        end
        run_op(2'b00, 32'd2, 32'd3, 1'b0);
        chk("mul_2x3_lo", bus.lo, 32'd6);

        for (int i = 0; i < 20; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            run_op(rop, ra, rb, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
